tl_channel_monitor: RTL
=======================

Name: tl_channel_monitor

Overview:
- Parametrised, stateful TileLink-UL A/D channel protocol monitor; the next generation of the per-port assertion blocks.
- Adds per-source in-flight tracking, multi-beat burst counting, payload-stability checks, a response watchdog, and sticky/first-error capture registers.
- Sits beside any TL-UL port in the testbench or debug wrapper and observes only; it never drives the bus.
- Errors are reported as registered outputs. An optional simulation-only fatal stop is also available.

Parameters:
SOURCE_BITS, 4, width of a_source/d_source; tracks 2^SOURCE_BITS IDs
SIZE_BITS, 4, width of a_size/d_size (log2 bytes)
ADDR_BITS, 32, width of a_address
DATA_BYTES, 8, beat width in bytes (power of 2); mask width
TIMEOUT, 1024, max cycles a source may stay in flight (0 disables)
STOP_ON_ERR, 0, 1: $fatal on any error (non-SYNTHESIS only)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  synchronous, active-high
a_valid  in  1  A channel valid
a_ready  in  1  A channel ready
a_opcode  in  3  0 PutFull, 1 PutPartial, 4 Get; others illegal
a_size  in  SIZE_BITS  log2 transfer bytes
a_source  in  SOURCE_BITS  request ID
a_address  in  ADDR_BITS  byte address
a_mask  in  DATA_BYTES  byte lanes
d_valid  in  1  D channel valid
d_ready  in  1  D channel ready
d_opcode  in  3  0 AccessAck, 1 AccessAckData
d_size  in  SIZE_BITS  response size
d_source  in  SOURCE_BITS  response ID
clear  in  1  clears sticky/first-error registers
err_valid  out  1  one-cycle pulse, registered
err_bits  out  8  errors detected in the previous cycle
err_sticky  out  8  OR-accumulated errors
first_err_code  out  8  err_bits of the first error since reset/clear
first_err_source  out  SOURCE_BITS  source of the first error
inflight_count  out  SOURCE_BITS+1  number of sources in flight

Behaviour:
- Handshakes: afire = a_valid & a_ready; dfire = d_valid & d_ready.
- Beat count: beats(size) = max(1, 2^size / DATA_BYTES).
  - A side: Put opcodes carry beats(size) beats; Get carries 1 beat.
  - D side: AccessAckData carries beats(size) beats; AccessAck carries 1 beat.
- Per-source state: inflight bit, recorded opcode (Get vs Put), recorded size, saturating age counter.
- A burst FSM:
  - A_IDLE -> A_BURST on a first-beat afire with beats>1. It latches opcode/size/source/address and sets a down-counter to beats-1.
  - Stays in A_BURST until the counter reaches 0 on an afire, then returns to A_IDLE.
- D burst FSM: identical structure, keyed on d_source.
- err_bits encoding (combinational detect, registered output):
  - [0] A_MASK: Get/PutFull mask != expected lane mask; PutPartial mask not a subset of it.
  - [1] A_ALIGN: address bits [size-1:0] nonzero, or opcode illegal.
  - [2] A_UNSTABLE: a_valid held high with !a_ready in the prior cycle, and any A field changed or a_valid dropped.
  - [3] A_SRC_BUSY: first-beat afire with a_source already in flight.
  - [4] A_BURST: during A_BURST, opcode/size/source/address differs from the latched values.
  - [5] D_SRC_IDLE: first-beat dfire with d_source not in flight.
  - [6] D_MISMATCH: d_size != recorded size, or d_opcode wrong for the recorded opcode (Get -> AccessAckData, Put -> AccessAck).
  - [7] TIMEOUT: any source age reaches TIMEOUT; reported once per source per transaction.
- Expected lane mask:
  - If 2^size >= DATA_BYTES: all ones.
  - Else: (2^(2^size) - 1) << (address mod DATA_BYTES).
- In-flight set/clear:
  - Set on the last A beat.
  - Cleared on the last D beat.
  - A set and a clear of the same source in the same cycle: the clear of the old transaction applies first, then the set; the source ends in flight.
- Age counters: reset to 0 on set; increment while in flight; saturate at TIMEOUT.
- Latency: every error appears on err_valid/err_bits exactly 1 cycle after the offending edge.
- Sticky and first-error registers:
  - err_sticky |= err_bits.
  - first_err_* load only when err_sticky == 0 and err_bits != 0.
  - clear zeroes err_sticky and first_err_*. If an error arrives in the same cycle as clear, it is captured after the clear (error wins).
- Reset state: all outputs 0; FSMs idle; inflight bits, counters and latched fields 0.
- Reset mid-burst: burst state is discarded, with no error on the following beats.

Test Plan:
- DATA_BYTES=8: Get size=2, addr=0x104, mask=0xF0 -> no error. Same request with mask=0x0F -> err_bits=0x01 one cycle later; first_err_source = a_source.
- PutFull size=5 (4 beats), source 3, addr changes on beat 2 -> err_bits[4]. Clean 4-beat Put -> inflight_count=1; AccessAck src 3 -> inflight_count=0.
- Second Get src 2 while src 2 is in flight -> 0x08. dfire AccessAck for idle src 5 -> 0x20. Get answered with AccessAck -> 0x40.
- a_valid=1, a_ready=0 with address changed next cycle -> 0x04. Stable for 5 stall cycles -> none.
- TIMEOUT=16: Get src 1, no response -> err_bits=0x80 at age 16, exactly once. clear -> err_sticky=0. Simultaneous clear + error -> sticky=that error.
- Same-cycle last-D and new-A for src 4 -> no error, src 4 in flight; assert reset mid-burst -> all outputs 0 next cycle.

Source files
------------

// File: rtl/tl_channel_monitor.sv
// TileLink-UL A/D channel protocol monitor. Purely passive: watches both
// channels, tracks per-source in-flight state and multi-beat bursts, and
// reports protocol violations as registered error pulses plus sticky and
// first-error capture registers.
module tl_channel_monitor #(
  parameter int SOURCE_BITS = 4,
  parameter int SIZE_BITS   = 4,
  parameter int ADDR_BITS   = 32,
  parameter int DATA_BYTES  = 8,
  parameter int TIMEOUT     = 1024,
  parameter int STOP_ON_ERR = 0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   a_valid,
  input  logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [SIZE_BITS-1:0]   a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [ADDR_BITS-1:0]   a_address,
  input  logic [DATA_BYTES-1:0]  a_mask,
  input  logic                   d_valid,
  input  logic                   d_ready,
  input  logic [2:0]             d_opcode,
  input  logic [SIZE_BITS-1:0]   d_size,
  input  logic [SOURCE_BITS-1:0] d_source,
  input  logic                   clear,
  output logic                   err_valid,
  output logic [7:0]             err_bits,
  output logic [7:0]             err_sticky,
  output logic [7:0]             first_err_code,
  output logic [SOURCE_BITS-1:0] first_err_source,
  output logic [SOURCE_BITS:0]   inflight_count
);

  localparam int NSRC  = 2 ** SOURCE_BITS;
  localparam int LG_DB = $clog2(DATA_BYTES);
  localparam int CNT_W = 2 ** SIZE_BITS;
  localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);
  localparam logic [AGE_W-1:0] AGE_HIT = AGE_W'(TIMEOUT - 1);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] OP_ACK      = 3'd0;
  localparam logic [2:0] OP_ACK_DATA = 3'd1;

  typedef enum logic {ST_IDLE, ST_BURST} burst_e;

  // Remaining beats after the first one: beats(size) - 1.
  function automatic logic [CNT_W-1:0] beats_m1(input logic [SIZE_BITS-1:0] size);
    if (int'(size) <= LG_DB) return '0;
    return (CNT_W'(1) << (int'(size) - LG_DB)) - CNT_W'(1);
  endfunction

  // Burst tracking state
  burst_e                 r_a_state, r_d_state;
  logic [CNT_W-1:0]       r_a_cnt, r_d_cnt;
  logic [2:0]             r_a_op;
  logic [SIZE_BITS-1:0]   r_a_size;
  logic [SOURCE_BITS-1:0] r_a_src, r_d_src;
  logic [ADDR_BITS-1:0]   r_a_addr;

  // Previous-cycle A channel snapshot for the stall stability check
  logic                   r_a_stall;
  logic [2:0]             r_p_op;
  logic [SIZE_BITS-1:0]   r_p_size;
  logic [SOURCE_BITS-1:0] r_p_src;
  logic [ADDR_BITS-1:0]   r_p_addr;
  logic [DATA_BYTES-1:0]  r_p_mask;

  // Per-source transaction records
  logic [NSRC-1:0]        r_inflight;
  logic [NSRC-1:0]        r_is_get;
  logic [SIZE_BITS-1:0]   r_size [NSRC];
  logic [AGE_W-1:0]       r_age  [NSRC];

  // Error reporting registers
  logic                   r_err_valid;
  logic [7:0]             r_err_bits, r_sticky, r_first_code;
  logic [SOURCE_BITS-1:0] r_first_src;

  logic                   w_afire, w_dfire;
  logic                   w_a_is_put, w_a_is_get, w_a_legal;
  logic                   w_a_first, w_a_last, w_a_set;
  logic [CNT_W-1:0]       w_a_m1, w_d_m1;
  logic [SOURCE_BITS-1:0] w_a_src_eff, w_d_src_eff;
  logic [SIZE_BITS-1:0]   w_a_size_eff;
  logic                   w_a_get_eff, w_a_legal_eff;
  logic                   w_d_first, w_d_last, w_d_clr;
  logic                   w_src_busy;
  logic [DATA_BYTES-1:0]  w_exp_mask;
  logic [ADDR_BITS-1:0]   w_align_mask;
  logic [NSRC-1:0]        w_set_vec, w_clr_vec, w_to;
  logic [SOURCE_BITS-1:0] w_to_src, w_err_src;
  logic [7:0]             w_err;
  logic [SOURCE_BITS:0]   w_count;

  assign w_afire    = a_valid & a_ready;
  assign w_dfire    = d_valid & d_ready;
  assign w_a_is_put = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
  assign w_a_is_get = (a_opcode == OP_GET);
  assign w_a_legal  = w_a_is_put | w_a_is_get;

  // Mid-burst beats are attributed to the transaction latched on the first beat.
  assign w_a_first     = (r_a_state == ST_IDLE);
  assign w_a_m1        = w_a_is_put ? beats_m1(a_size) : '0;
  assign w_a_last      = w_a_first ? (w_a_m1 == '0) : (r_a_cnt == CNT_W'(1));
  assign w_a_src_eff   = w_a_first ? a_source   : r_a_src;
  assign w_a_size_eff  = w_a_first ? a_size     : r_a_size;
  assign w_a_get_eff   = w_a_first & w_a_is_get;
  assign w_a_legal_eff = w_a_first ? w_a_legal  : 1'b1;
  assign w_a_set       = w_afire & w_a_last & w_a_legal_eff;

  assign w_d_first   = (r_d_state == ST_IDLE);
  assign w_d_m1      = (d_opcode == OP_ACK_DATA) ? beats_m1(d_size) : '0;
  assign w_d_last    = w_d_first ? (w_d_m1 == '0) : (r_d_cnt == CNT_W'(1));
  assign w_d_src_eff = w_d_first ? d_source : r_d_src;
  assign w_d_clr     = w_dfire & w_d_last;

  // A source retiring on D in this very cycle is free for a new request.
  assign w_src_busy   = r_inflight[a_source] & ~(w_d_clr & (w_d_src_eff == a_source));
  assign w_align_mask = (ADDR_BITS'(1) << a_size) - ADDR_BITS'(1);

  // Expected byte-lane mask for the current A beat
  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    int off, nb;
    off        = int'(a_address & ADDR_BITS'(DATA_BYTES - 1));
    nb         = 1 << a_size;
    w_exp_mask = '0;
    for (int i = 0; i < DATA_BYTES; i++)
      w_exp_mask[i] = (int'(a_size) >= LG_DB) || ((i >= off) && (i < off + nb));
  end

  // Per-source set/clear strobes, timeout detection and in-flight population count
  always_comb begin
    w_set_vec = '0;
    w_clr_vec = '0;
    w_to      = '0;
    w_to_src  = '0;
    w_count   = '0;
    for (int s = 0; s < NSRC; s++) begin
      w_set_vec[s] = w_a_set & (w_a_src_eff == SOURCE_BITS'(s));
      w_clr_vec[s] = w_d_clr & (w_d_src_eff == SOURCE_BITS'(s));
      w_to[s]      = (TIMEOUT > 0) & r_inflight[s] & ~w_set_vec[s] & ~w_clr_vec[s] &
                     (r_age[s] == AGE_HIT);
      w_count      = w_count + (SOURCE_BITS + 1)'(r_inflight[s]);
    end
    for (int s = NSRC - 1; s >= 0; s--)
      if (w_to[s]) w_to_src = SOURCE_BITS'(s);
  end

  // Combinational error detection and the source each error is charged to
  always_comb begin
    w_err = '0;
    if (w_afire) begin
      if (a_opcode == OP_PUT_PART) w_err[0] = |(a_mask & ~w_exp_mask);
      else if (w_a_legal)          w_err[0] = (a_mask != w_exp_mask);
      w_err[1] = (|(a_address & w_align_mask)) | ~w_a_legal;
      w_err[3] = w_a_first & w_src_busy;
      w_err[4] = ~w_a_first & ((a_opcode != r_a_op) || (a_size != r_a_size) ||
                               (a_source != r_a_src) || (a_address != r_a_addr));
    end
    w_err[2] = r_a_stall & (~a_valid || (a_opcode != r_p_op) || (a_size != r_p_size) ||
                            (a_source != r_p_src) || (a_address != r_p_addr) ||
                            (a_mask != r_p_mask));
    if (w_dfire && w_d_first) begin
      if (!r_inflight[d_source]) w_err[5] = 1'b1;
      else w_err[6] = (d_size != r_size[d_source]) ||
                      (r_is_get[d_source] ? (d_opcode != OP_ACK_DATA) : (d_opcode != OP_ACK));
    end
    w_err[7] = |w_to;
    if (|w_err[4:0])      w_err_src = a_source;
    else if (|w_err[6:5]) w_err_src = d_source;
    else                  w_err_src = w_to_src;
  end

  // A burst FSM: latch the first beat of a multi-beat Put and count remaining beats
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_state <= ST_IDLE;
      r_a_cnt   <= '0;
      r_a_op    <= '0;
      r_a_size  <= '0;
      r_a_src   <= '0;
      r_a_addr  <= '0;
    end else if (w_afire) begin
      if (r_a_state == ST_IDLE) begin
        if (w_a_m1 != '0) begin
          r_a_state <= ST_BURST;
          r_a_cnt   <= w_a_m1;
          r_a_op    <= a_opcode;
          r_a_size  <= a_size;
          r_a_src   <= a_source;
          r_a_addr  <= a_address;
        end
      end else begin
        r_a_cnt <= r_a_cnt - CNT_W'(1);
        if (r_a_cnt == CNT_W'(1)) r_a_state <= ST_IDLE;
      end
    end
  end

  // D burst FSM: same structure, keyed on d_source
  always_ff @(posedge clock) begin
    if (reset) begin
      r_d_state <= ST_IDLE;
      r_d_cnt   <= '0;
      r_d_src   <= '0;
    end else if (w_dfire) begin
      if (r_d_state == ST_IDLE) begin
        if (w_d_m1 != '0) begin
          r_d_state <= ST_BURST;
          r_d_cnt   <= w_d_m1;
          r_d_src   <= d_source;
        end
      end else begin
        r_d_cnt <= r_d_cnt - CNT_W'(1);
        if (r_d_cnt == CNT_W'(1)) r_d_state <= ST_IDLE;
      end
    end
  end

  // Snapshot of the A channel for next-cycle stall stability comparison
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a_stall <= 1'b0;
      r_p_op    <= '0;
      r_p_size  <= '0;
      r_p_src   <= '0;
      r_p_addr  <= '0;
      r_p_mask  <= '0;
    end else begin
      r_a_stall <= a_valid & ~a_ready;
      r_p_op    <= a_opcode;
      r_p_size  <= a_size;
      r_p_src   <= a_source;
      r_p_addr  <= a_address;
      r_p_mask  <= a_mask;
    end
  end

  // Per-source records: a set overrides a same-cycle clear so the new transaction survives
  // NOTE: the per-source arrays are reset too, so a freshly reset monitor never sees stale IDs.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_inflight <= '0;
      r_is_get   <= '0;
      for (int s = 0; s < NSRC; s++) begin
        r_size[s] <= '0;
        r_age[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < NSRC; s++) begin
        if (w_set_vec[s]) begin
          r_inflight[s] <= 1'b1;
          r_is_get[s]   <= w_a_get_eff;
          r_size[s]     <= w_a_size_eff;
          r_age[s]      <= '0;
        end else if (w_clr_vec[s]) begin
          r_inflight[s] <= 1'b0;
          r_age[s]      <= '0;
        end else if (r_inflight[s] && (r_age[s] != AGE_MAX)) begin
          r_age[s] <= r_age[s] + AGE_W'(1);
        end
      end
    end
  end

  // Error pulse, sticky accumulation and first-error capture (a same-cycle error beats clear)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err_valid  <= 1'b0;
      r_err_bits   <= '0;
      r_sticky     <= '0;
      r_first_code <= '0;
      r_first_src  <= '0;
    end else begin
      r_err_valid <= |w_err;
      r_err_bits  <= w_err;
      if (clear) begin
        r_sticky     <= w_err;
        r_first_code <= w_err;
        r_first_src  <= (|w_err) ? w_err_src : '0;
      end else begin
        r_sticky <= r_sticky | w_err;
        if ((r_sticky == '0) && (|w_err)) begin
          r_first_code <= w_err;
          r_first_src  <= w_err_src;
        end
      end
    end
  end

`ifndef SYNTHESIS
  generate
    if (STOP_ON_ERR != 0) begin : g_stop
      // Optional hard stop for simulation runs that should die on the first violation
      always_ff @(posedge clock) begin
        if (!reset && r_err_valid) $fatal(1, "tl_channel_monitor: protocol error 0x%02h", r_err_bits);
      end
    end
  endgenerate
`endif

  assign err_valid        = r_err_valid;
  assign err_bits         = r_err_bits;
  assign err_sticky       = r_sticky;
  assign first_err_code   = r_first_code;
  assign first_err_source = r_first_src;
  assign inflight_count   = w_count;

endmodule
